mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-outstanding memory bus port between the IF stage (instruction fetch) and
//  the MEM stage (loads/stores) of the 32-bit RISC-V pipeline. It arbitrates between them
//  (data priority with anti-starvation), generates byte strobes, and returns per-requester
//  ack/rdata/err. It also enforces alignment and a bus timeout. Sits between the core and the
//  SoC memory interconnect.
// PARAMETERS
//  ADDR_W         32  address width, bus and requesters
//  TIMEOUT_CYCLES 16  max cycles in BUSY without bus_ack before error (>=2)
//  STARVE_LIMIT   4   consecutive data grants allowed while if_req pending (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held with if_addr stable until if_ack/if_err
//  if_addr    in   ADDR_W  fetch address (word aligned)
//  if_rdata   out  32      fetched instruction, valid with if_ack
//  if_ack     out  1       1-cycle pulse: fetch done OK
//  if_err     out  1       1-cycle pulse: fetch misaligned or timed out
//  d_req      in   1       data request; d_* held stable until d_ack/d_err
//  d_we       in   1       1=store, 0=load
//  d_size     in   2       0=byte 1=half 2=word (3 treated as word)
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  d_rdata    out  32      raw loaded word (no extraction/sign-ext), valid with d_ack
//  d_ack      out  1       1-cycle pulse: data access done OK
//  d_err      out  1       1-cycle pulse: data misaligned or timed out
//  bus_req    out  1       bus request, registered; held until bus_ack or timeout
//  bus_we     out  1       bus write enable, registered
//  bus_addr   out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}, registered
//  bus_wstrb  out  4       byte strobes, registered; 4'b0000 for reads
//  bus_wdata  out  32      lane-shifted store data, registered
//  bus_rdata  in   32      read data, sampled when bus_ack=1
//  bus_ack    in   1       bus completion, valid only while bus_req=1
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0; bus_req drops asynchronously mid-transfer,
//    in-flight transfer is abandoned (no ack/err issued).
//  - FSM states: IDLE, BUSY_I, BUSY_D, RESP.
//  - IDLE, arbitration:
//    - d_req only -> data wins; if_req only -> fetch wins.
//    - Both -> data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
//    - starve_cnt increments per data grant made while if_req=1 (saturating), clears on fetch grant.
//  - Misaligned winner -> RESP directly with err, no bus cycle.
//    - Fetch: if_addr[1:0]!=0.
//    - Data: half with addr[0]=1, or word with addr[1:0]!=0.
//  - Aligned winner -> BUSY_x; bus_req/bus_* registered, high from the next cycle.
//  - BUSY_x: timeout counter counts cycles.
//    - bus_ack=1 -> capture bus_rdata, bus_req<=0, go RESP with ack.
//    - Counter reaches TIMEOUT_CYCLES-1 without bus_ack -> bus_req<=0, go RESP with err.
//    - bus_ack in that same final cycle wins (ack, not err).
//  - RESP: exactly one of x_ack/x_err pulses for the winner this cycle, then IDLE.
//    - Requester deasserts req or presents a new request by the end of the RESP cycle.
//  - Latency: req seen in IDLE cycle N -> bus_req cycle N+1. With 0-wait memory (bus_ack in
//    N+1): ack in N+2, next grant decision N+3. Misaligned: err in N+1.
//  - Strobes/data:
//    - Byte: wstrb=4'b0001<<a[1:0], wdata={4{wd[7:0]}}.
//    - Half: wstrb=4'b0011<<{a[1],1'b0}, wdata={2{wd[15:0]}}.
//    - Word: wstrb=4'b1111, wdata=wd.
//    - Reads: wstrb=0, bus_we=0.
//  - Only one bus transaction outstanding; bus_* stable while bus_req=1.
//  - if_rdata/d_rdata hold the last captured value between acks.
// TESTING
//  - Fetch only, if_addr=0x100, bus_ack 2 cycles after bus_req -> bus_addr=0x100,
//    if_rdata=bus_rdata, if_ack single pulse.
//  - Store byte, d_addr=0x203, d_wdata=0xAB -> bus_wstrb=4'b1000, bus_wdata=0xABABABAB,
//    bus_addr=0x200, d_ack.
//  - Both requesters held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D..., never
//    two fetches back-to-back.
//  - Load word d_addr=0x102 -> d_err pulse 1 cycle after req; bus_req never asserts.
//  - bus_ack never returns, TIMEOUT_CYCLES=16 -> bus_req low after 16 cycles, err pulse,
//    arbiter serves next request.
//  - reset asserted mid BUSY_D -> bus_req low immediately, no d_ack/d_err; after release a
//    fresh fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester ports and the shared memory bus port
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;
   logic              if_err;
   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ack;
   logic              d_err;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_wstrb;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;
   logic              bus_ack;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_rdata, bus_ack,
      output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_rdata, bus_ack,
      input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding bus port between fetch and data requesters
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int STARVE_LIMIT   = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave mp
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
   state_t        r_state;
   logic [SW-1:0] r_starve;
   logic [TW-1:0] r_tmo;
   logic          w_grant_d;
   logic          w_if_mis;
   logic          w_d_mis;
   logic          w_tmo;
   logic          w_is_d;
   logic [3:0]    w_wstrb;
   logic [31:0]   w_wdata;
   always_comb begin
      w_grant_d = mp.d_req && !(mp.if_req && r_starve == SW'(STARVE_LIMIT));
      w_if_mis  = |mp.if_addr[1:0];
      w_d_mis   = (mp.d_size == 2'd1 && mp.d_addr[0]) || (mp.d_size[1] && |mp.d_addr[1:0]);
      w_tmo     = r_tmo == TW'(TIMEOUT_CYCLES - 1);
      w_is_d    = r_state == BUSY_D;
      w_wstrb   = !mp.d_we ? 4'b0000 :
                  mp.d_size == 2'd0 ? 4'b0001 << mp.d_addr[1:0] :
                  mp.d_size == 2'd1 ? 4'b0011 << {mp.d_addr[1], 1'b0} : 4'b1111;
      w_wdata   = mp.d_size == 2'd0 ? {4{mp.d_wdata[7:0]}} :
                  mp.d_size == 2'd1 ? {2{mp.d_wdata[15:0]}} : mp.d_wdata;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve     <= '0;
         r_tmo        <= '0;
         mp.if_rdata  <= '0;
         mp.if_ack    <= 1'b0;
         mp.if_err    <= 1'b0;
         mp.d_rdata   <= '0;
         mp.d_ack     <= 1'b0;
         mp.d_err     <= 1'b0;
         mp.bus_req   <= 1'b0;
         mp.bus_we    <= 1'b0;
         mp.bus_addr  <= '0;
         mp.bus_wstrb <= '0;
         mp.bus_wdata <= '0;
      end else begin
         mp.if_ack <= 1'b0;
         mp.if_err <= 1'b0;
         mp.d_ack  <= 1'b0;
         mp.d_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  // fetch pending while data wins: one step closer to forcing a fetch grant
                  if (mp.if_req) r_starve <= r_starve + SW'(1);
                  if (w_d_mis) begin
                     mp.d_err <= 1'b1;
                     r_state  <= RESP;
                  end else begin
                     mp.bus_req   <= 1'b1;
                     mp.bus_we    <= mp.d_we;
                     mp.bus_addr  <= {mp.d_addr[ADDR_W-1:2], 2'b00};
                     mp.bus_wstrb <= w_wstrb;
                     mp.bus_wdata <= w_wdata;
                     r_state      <= BUSY_D;
                  end
               end else if (mp.if_req) begin
                  r_starve <= '0;
                  if (w_if_mis) begin
                     mp.if_err <= 1'b1;
                     r_state   <= RESP;
                  end else begin
                     mp.bus_req   <= 1'b1;
                     mp.bus_we    <= 1'b0;
                     mp.bus_addr  <= {mp.if_addr[ADDR_W-1:2], 2'b00};
                     mp.bus_wstrb <= 4'b0000;
                     r_state      <= BUSY_I;
                  end
               end
            end
            RESP: r_state <= IDLE;
            default: begin
               // an ack in the final timeout cycle still completes the access normally
               if (mp.bus_ack || w_tmo) begin
                  mp.bus_req <= 1'b0;
                  r_tmo      <= '0;
                  r_state    <= RESP;
                  if (w_is_d) begin
                     mp.d_ack <= mp.bus_ack;
                     mp.d_err <= !mp.bus_ack;
                     if (mp.bus_ack) mp.d_rdata <= mp.bus_rdata;
                  end else begin
                     mp.if_ack <= mp.bus_ack;
                     mp.if_err <= !mp.bus_ack;
                     if (mp.bus_ack) mp.if_rdata <= mp.bus_rdata;
                  end
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
         endcase
      end
   end
endmodule
